controle_rega: RTL and testbench
================================

# controle_rega

Sequential irrigation controller that owns the sprinkler (aspersão), drip (gotejamento), tank-fill (VE) and cleaning (limpeza) valves. It arbitrates mode requests against soil and tank-level sensors and times each phase with a tick-driven timer. It raises a latched, coded error on sensor conflicts or a fill timeout. It sits between the user mode switches and sensors on one side and the valve drivers and status display on the other.

## Interface

- ASP_TICKS, 60: sprinkler phase length in ticks (≥1)
- GOT_TICKS, 120: drip phase length in ticks (≥1)
- FILL_TIMEOUT, 200: maximum fill phase length in ticks before a fault
- CLEAN_TICKS, 30: cleaning phase length in ticks
- CLEAN_EVERY, 4: completed irrigations between automatic cleanings
- TIMER_W, 16: timer width; every *_TICKS value must be < 2^TIMER_W

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle timebase enable; timers advance only when tick=1
- req_asp  in  1  sprinkler mode requested
- req_got  in  1  drip mode requested
- solo_seco  in  1  soil moisture below threshold
- nivel_min  in  1  tank above minimum level
- nivel_max  in  1  tank full
- err_ack  in  1  operator error acknowledge
- rega  out  2  [1]=sprinkler valve, [0]=drip valve
- ve  out  1  fill valve
- limpeza  out  1  cleaning valve
- erro  out  1  fault latched
- err_code  out  2  00 none, 01 asp/got conflict, 10 fill timeout, 11 level sensors inconsistent
- estado  out  3  current state code

## Operation

- States and codes: IDLE=000, FILL=001, ASP=010, GOT=011, CLEAN=100, ERROR=101.
- Global fault checks, evaluated in every state except ERROR, in priority order:
  - req_asp&req_got → ERROR, code 01.
  - nivel_max&~nivel_min → ERROR, code 11.
- IDLE transitions, first match wins:
  - ~nivel_min → FILL.
  - clean_due → CLEAN.
  - solo_seco&req_asp → ASP.
  - solo_seco&req_got → GOT.
- FILL: ve=1.
  - nivel_max → IDLE.
  - Timer reaching FILL_TIMEOUT ticks → ERROR, code 10.
- ASP: rega=10. GOT: rega=01.
  - Both exit to IDLE after their *_TICKS ticks, or early on ~solo_seco, request drop, or ~nivel_min.
  - Every exit from ASP/GOT increments irr_cnt, saturating at CLEAN_EVERY.
- CLEAN: limpeza=1. Exits to IDLE after CLEAN_TICKS ticks and clears irr_cnt.
- ERROR: rega=00, ve=0, limpeza=0, erro=1. err_code holds the first fault.
  - err_ack=1 and no global fault condition present → IDLE, err_code→00.
  - err_ack while the fault persists is ignored.
- Invariant: at most one of {rega[1], rega[0], ve, limpeza} is 1 in any cycle.
- Unused state codes → IDLE on the next clock.

## Timing

- All outputs are registered and change on the same clock edge as the state register.
- Reset (reset_n=0, asynchronous): state IDLE, estado=000, rega=00, ve=0, limpeza=0, erro=0, err_code=00, timer=0, irr_cnt=0.
- Timer clears on every state entry and increments on cycles with tick=1.
- A timed exit occurs on the edge where tick=1 and timer==N-1, so the phase lasts exactly N ticks.
- Early-exit and fault conditions act on the next clock edge, independent of tick.
- Fault and timed exit in the same cycle: the fault wins.
- Reset asserted mid-phase: valves close immediately. irr_cnt is not incremented.

## Configuration

- AUTO_CLEAN_EN defined: irr_cnt and the CLEAN state are implemented. clean_due = (irr_cnt==CLEAN_EVERY).
- AUTO_CLEAN_EN undefined: clean_due is tied to 0, irr_cnt is removed, and limpeza is constant 0. State code 100 is unreachable and recovers to IDLE.

## Test plan

- Reset, tank ok, solo_seco=1, req_asp=1, ASP_TICKS=3, tick every 4 clk → rega=10 for exactly 3 ticks, then IDLE with rega=00.
- In GOT, drop solo_seco mid-phase → next edge rega=00, estado=000, irr_cnt incremented.
- nivel_min=0 in IDLE, nivel_max never rises, FILL_TIMEOUT=5 → ve=1 for 5 ticks, then erro=1, err_code=10. err_ack with nivel_min still 0 keeps ERROR.
- req_asp=req_got=1 during ASP → next edge rega=00, erro=1, err_code=01. Release one request, pulse err_ack → IDLE, err_code=00.
- AUTO_CLEAN_EN, CLEAN_EVERY=2: two complete irrigations → CLEAN with limpeza=1 for CLEAN_TICKS ticks, irr_cnt=0 afterwards. Without the macro, limpeza stays 0 throughout.
- Assert reset_n=0 mid-FILL asynchronously → ve=0 before the next clock edge, estado=000.

Source files
------------

// File: rtl/controle_rega_if.sv
// rtl/controle_rega_if.sv - mode, sensor and valve signal bundle for controle_rega
//
// Purpose: groups the user/sensor inputs and the valve/status outputs of the
// irrigation controller into one bundle.
//   master : drives tick, req_asp, req_got, solo_seco, nivel_min, nivel_max, err_ack
//            and observes rega, ve, limpeza, erro, err_code, estado
//   slave  : the controller side (inputs/outputs mirrored)
interface controle_rega_if;
  logic       tick;
  logic       req_asp;
  logic       req_got;
  logic       solo_seco;
  logic       nivel_min;
  logic       nivel_max;
  logic       err_ack;
  logic [1:0] rega;
  logic       ve;
  logic       limpeza;
  logic       erro;
  logic [1:0] err_code;
  logic [2:0] estado;

  modport master (
    output tick, req_asp, req_got, solo_seco, nivel_min, nivel_max, err_ack,
    input  rega, ve, limpeza, erro, err_code, estado
  );

  modport slave (
    input  tick, req_asp, req_got, solo_seco, nivel_min, nivel_max, err_ack,
    output rega, ve, limpeza, erro, err_code, estado
  );
endinterface

// File: rtl/controle_rega.sv
// rtl/controle_rega.sv - tick-timed irrigation controller with latched fault codes
//
// Purpose: arbitrates sprinkler/drip requests against soil and tank sensors,
// fills the tank, optionally runs periodic cleaning, and latches the first fault.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      controle_rega_if.slave
//            in : tick, req_asp, req_got, solo_seco, nivel_min, nivel_max, err_ack
//            out: rega[1]=sprinkler, rega[0]=drip, ve=fill, limpeza=cleaning,
//                 erro, err_code, estado (all registered)
// Build option: define AUTO_CLEAN_EN to implement irr_cnt and the CLEAN state;
// without it limpeza is constant 0 and code 100 recovers to IDLE.
module controle_rega #(
  parameter int ASP_TICKS    = 60,
  parameter int GOT_TICKS    = 120,
  parameter int FILL_TIMEOUT = 200,
  parameter int CLEAN_TICKS  = 30,
  parameter int CLEAN_EVERY  = 4,
  parameter int TIMER_W      = 16
) (
  input logic             clk,
  input logic             reset_n,
  controle_rega_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_FILL  = 3'b001,
    S_ASP   = 3'b010,
    S_GOT   = 3'b011,
    S_CLEAN = 3'b100,
    S_ERROR = 3'b101
  } state_t;

  // Range guard: a tick count that does not fit the timer leaves this marker
  // block in the elaborated hierarchy.
  if (ASP_TICKS >= (1 << TIMER_W) || GOT_TICKS >= (1 << TIMER_W) ||
      FILL_TIMEOUT >= (1 << TIMER_W) || CLEAN_TICKS >= (1 << TIMER_W) ||
      CLEAN_EVERY < 1) begin : g_param_out_of_range
  end

  state_t             state, state_nxt;
  logic [TIMER_W-1:0] timer;
  logic [1:0]         err_code_q, err_code_nxt;
  logic [1:0]         rega_q, rega_nxt;
  logic               ve_q, ve_nxt, limpeza_q, limpeza_nxt, erro_q, erro_nxt;
  logic               clean_due;
  logic               conflict, lvl_bad, fault_persists;

  assign conflict = bus.req_asp & bus.req_got;
  assign lvl_bad  = bus.nivel_max & ~bus.nivel_min;
  // A fill timeout is still present while the tank stays below minimum;
  // acknowledging it then would only restart the failed fill.
  assign fault_persists = conflict | lvl_bad | ((err_code_q == 2'b10) & ~bus.nivel_min);

`ifdef AUTO_CLEAN_EN
  localparam int IW = $clog2(CLEAN_EVERY + 1);
  logic [IW-1:0] irr_cnt;
  assign clean_due = (irr_cnt == IW'(CLEAN_EVERY));

  // Any exit from ASP/GOT (timed, early or fault) counts one irrigation;
  // only a completed cleaning clears the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irr_cnt <= '0;
    end else if ((state == S_ASP || state == S_GOT) && state_nxt != state) begin
      if (!clean_due) irr_cnt <= irr_cnt + 1'b1;
    end else if (state == S_CLEAN && state_nxt == S_IDLE) begin
      irr_cnt <= '0;
    end
  end
`else
  assign clean_due = 1'b0;
`endif

  // State, timer and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      timer      <= '0;
      err_code_q <= 2'b00;
      rega_q     <= 2'b00;
      ve_q       <= 1'b0;
      limpeza_q  <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      err_code_q <= err_code_nxt;
      rega_q     <= rega_nxt;
      ve_q       <= ve_nxt;
      limpeza_q  <= limpeza_nxt;
      erro_q     <= erro_nxt;
      if (state_nxt != state) timer <= '0;
      else if (bus.tick)      timer <= timer + 1'b1;
    end
  end

  // Next state. Global faults are tested first so they beat a timed exit.
  always_comb begin
    state_nxt    = state;
    err_code_nxt = err_code_q;
    case (state)
      S_IDLE, S_FILL, S_ASP, S_GOT
`ifdef AUTO_CLEAN_EN
      , S_CLEAN
`endif
      : begin
        if (conflict) begin
          state_nxt    = S_ERROR;
          err_code_nxt = 2'b01;
        end else if (lvl_bad) begin
          state_nxt    = S_ERROR;
          err_code_nxt = 2'b11;
        end else begin
          case (state)
            S_IDLE: begin
              if (!bus.nivel_min)                    state_nxt = S_FILL;
              else if (clean_due)                    state_nxt = S_CLEAN;
              else if (bus.solo_seco && bus.req_asp) state_nxt = S_ASP;
              else if (bus.solo_seco && bus.req_got) state_nxt = S_GOT;
            end
            S_FILL: begin
              if (bus.nivel_max) begin
                state_nxt = S_IDLE;
              end else if (bus.tick && timer == TIMER_W'(FILL_TIMEOUT - 1)) begin
                state_nxt    = S_ERROR;
                err_code_nxt = 2'b10;
              end
            end
            S_ASP: begin
              if (!bus.solo_seco || !bus.req_asp || !bus.nivel_min ||
                  (bus.tick && timer == TIMER_W'(ASP_TICKS - 1)))
                state_nxt = S_IDLE;
            end
            S_GOT: begin
              if (!bus.solo_seco || !bus.req_got || !bus.nivel_min ||
                  (bus.tick && timer == TIMER_W'(GOT_TICKS - 1)))
                state_nxt = S_IDLE;
            end
            default: begin
              if (bus.tick && timer == TIMER_W'(CLEAN_TICKS - 1)) state_nxt = S_IDLE;
            end
          endcase
        end
      end
      S_ERROR: begin
        if (bus.err_ack && !fault_persists) begin
          state_nxt    = S_IDLE;
          err_code_nxt = 2'b00;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so outputs switch with the state register.
  always_comb begin
    rega_nxt    = {state_nxt == S_ASP, state_nxt == S_GOT};
    ve_nxt      = (state_nxt == S_FILL);
    erro_nxt    = (state_nxt == S_ERROR);
`ifdef AUTO_CLEAN_EN
    limpeza_nxt = (state_nxt == S_CLEAN);
`else
    limpeza_nxt = 1'b0;
`endif
  end

  assign bus.rega     = rega_q;
  assign bus.ve       = ve_q;
  assign bus.limpeza  = limpeza_q;
  assign bus.erro     = erro_q;
  assign bus.err_code = err_code_q;
  assign bus.estado   = state;

endmodule

// File: tb/tb_controle_rega.sv
// tb/tb_controle_rega.sv - directed self-checking bench for controle_rega
module tb_controle_rega;
  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  controle_rega_if bus ();

  controle_rega #(
    .ASP_TICKS    (3),
    .GOT_TICKS    (4),
    .FILL_TIMEOUT (5),
    .CLEAN_TICKS  (2),
    .CLEAN_EVERY  (2),
    .TIMER_W      (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  // One timebase tick: three idle clocks then one clock with tick=1.
  task automatic do_tick();
    bus.tick = 1'b0;
    repeat (3) clk1();
    bus.tick = 1'b1;
    clk1();
    bus.tick = 1'b0;
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.tick      = 1'b0;
    bus.req_asp   = 1'b0;
    bus.req_got   = 1'b0;
    bus.solo_seco = 1'b0;
    bus.nivel_min = 1'b1;
    bus.nivel_max = 1'b0;
    bus.err_ack   = 1'b0;
    repeat (2) clk1();
    chk("rst_estado", {1'b0, bus.estado}, 4'h0);
    chk("rst_rega", {2'b0, bus.rega}, 4'h0);
    chk("rst_ve", {3'b0, bus.ve}, 4'h0);
    chk("rst_limpeza", {3'b0, bus.limpeza}, 4'h0);
    chk("rst_erro", {3'b0, bus.erro}, 4'h0);
    chk("rst_code", {2'b0, bus.err_code}, 4'h0);
    reset_n = 1'b1;
    clk1();
    chk("idle_dry_off", {1'b0, bus.estado}, 4'h0);

    // Sprinkler runs exactly three ticks.
    bus.solo_seco = 1'b1;
    bus.req_asp   = 1'b1;
    clk1();
    chk("asp_enter_estado", {1'b0, bus.estado}, 4'h2);
    chk("asp_enter_rega", {2'b0, bus.rega}, 4'h2);
    do_tick();
    chk("asp_t1_rega", {2'b0, bus.rega}, 4'h2);
    do_tick();
    chk("asp_t2_rega", {2'b0, bus.rega}, 4'h2);
    do_tick();
    chk("asp_t3_estado", {1'b0, bus.estado}, 4'h0);
    chk("asp_t3_rega", {2'b0, bus.rega}, 4'h0);
    bus.req_asp = 1'b0;

    // Drip aborted by wet soil.
    bus.req_got = 1'b1;
    clk1();
    chk("got_enter_rega", {2'b0, bus.rega}, 4'h1);
    do_tick();
    chk("got_t1_estado", {1'b0, bus.estado}, 4'h3);
    bus.solo_seco = 1'b0;
    clk1();
    chk("got_drop_estado", {1'b0, bus.estado}, 4'h0);
    chk("got_drop_rega", {2'b0, bus.rega}, 4'h0);
    bus.req_got   = 1'b0;
    bus.solo_seco = 1'b1;
    clk1();
`ifdef AUTO_CLEAN_EN
    chk("clean1_estado", {1'b0, bus.estado}, 4'h4);
    chk("clean1_limpeza", {3'b0, bus.limpeza}, 4'h1);
    do_tick();
    chk("clean1_t1", {3'b0, bus.limpeza}, 4'h1);
    do_tick();
    chk("clean1_done_estado", {1'b0, bus.estado}, 4'h0);
    chk("clean1_done_limpeza", {3'b0, bus.limpeza}, 4'h0);
`else
    chk("noclean1_estado", {1'b0, bus.estado}, 4'h0);
    chk("noclean1_limpeza", {3'b0, bus.limpeza}, 4'h0);
`endif

    // Fill never reaches full: timeout after five ticks.
    bus.nivel_min = 1'b0;
    clk1();
    chk("fill_enter_ve", {3'b0, bus.ve}, 4'h1);
    repeat (4) do_tick();
    chk("fill_t4_ve", {3'b0, bus.ve}, 4'h1);
    do_tick();
    chk("fill_to_estado", {1'b0, bus.estado}, 4'h5);
    chk("fill_to_code", {2'b0, bus.err_code}, 4'h2);
    chk("fill_to_ve", {3'b0, bus.ve}, 4'h0);
    chk("fill_to_erro", {3'b0, bus.erro}, 4'h1);
    bus.err_ack = 1'b1;
    clk1();
    chk("fill_ack_held", {1'b0, bus.estado}, 4'h5);
    chk("fill_ack_code", {2'b0, bus.err_code}, 4'h2);
    bus.nivel_min = 1'b1;
    clk1();
    chk("fill_clr_estado", {1'b0, bus.estado}, 4'h0);
    chk("fill_clr_code", {2'b0, bus.err_code}, 4'h0);
    chk("fill_clr_erro", {3'b0, bus.erro}, 4'h0);
    bus.err_ack = 1'b0;

    // Request conflict during sprinkling.
    bus.req_asp = 1'b1;
    clk1();
    chk("cf_asp", {2'b0, bus.rega}, 4'h2);
    bus.req_got = 1'b1;
    clk1();
    chk("cf_rega", {2'b0, bus.rega}, 4'h0);
    chk("cf_erro", {3'b0, bus.erro}, 4'h1);
    chk("cf_code", {2'b0, bus.err_code}, 4'h1);
    bus.err_ack = 1'b1;
    clk1();
    chk("cf_ack_held", {1'b0, bus.estado}, 4'h5);
    bus.req_got = 1'b0;
    clk1();
    chk("cf_clr_estado", {1'b0, bus.estado}, 4'h0);
    chk("cf_clr_code", {2'b0, bus.err_code}, 4'h0);
    bus.req_asp = 1'b0;
    bus.err_ack = 1'b0;

    // Inconsistent level sensors.
    bus.nivel_max = 1'b1;
    bus.nivel_min = 1'b0;
    clk1();
    chk("lvl_code", {2'b0, bus.err_code}, 4'h3);
    chk("lvl_ve", {3'b0, bus.ve}, 4'h0);
    bus.nivel_min = 1'b1;
    bus.err_ack   = 1'b1;
    clk1();
    chk("lvl_clr", {1'b0, bus.estado}, 4'h0);
    bus.nivel_max = 1'b0;
    bus.err_ack   = 1'b0;

    // Fault in the same cycle as the final sprinkler tick: fault wins.
    bus.req_asp = 1'b1;
    clk1();
    repeat (2) do_tick();
    repeat (3) clk1();
    bus.tick    = 1'b1;
    bus.req_got = 1'b1;
    clk1();
    bus.tick    = 1'b0;
    chk("race_estado", {1'b0, bus.estado}, 4'h5);
    chk("race_code", {2'b0, bus.err_code}, 4'h1);
    bus.req_got = 1'b0;
    bus.req_asp = 1'b0;
    bus.err_ack = 1'b1;
    clk1();
    chk("race_clr", {1'b0, bus.estado}, 4'h0);
    bus.err_ack = 1'b0;
    clk1();
`ifdef AUTO_CLEAN_EN
    chk("clean2_limpeza", {3'b0, bus.limpeza}, 4'h1);
    repeat (2) do_tick();
    chk("clean2_done", {1'b0, bus.estado}, 4'h0);
`else
    chk("noclean2_limpeza", {3'b0, bus.limpeza}, 4'h0);
    chk("noclean2_estado", {1'b0, bus.estado}, 4'h0);
`endif

    // Asynchronous reset in the middle of a fill.
    bus.nivel_min = 1'b0;
    clk1();
    chk("ar_fill_ve", {3'b0, bus.ve}, 4'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_ve", {3'b0, bus.ve}, 4'h0);
    chk("ar_estado", {1'b0, bus.estado}, 4'h0);
    clk1();
    reset_n       = 1'b1;
    bus.nivel_min = 1'b1;
    clk1();
    chk("ar_after", {1'b0, bus.estado}, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
